// File: rtl/control_sequencer_if.sv
// Control/observe bundle between the sequencer and the ALU-system datapath.
// The master side drives every datapath control and watches IROut/FlagsOut.
interface control_sequencer_if;
  logic [15:0] IROut;
  logic [3:0]  FlagsOut;
  logic [2:0]  RF_OutASel;
  logic [2:0]  RF_OutBSel;
  logic [2:0]  RF_FunSel;
  logic [3:0]  RF_RegSel;
  logic [3:0]  RF_ScrSel;
  logic [1:0]  ARF_OutCSel;
  logic [1:0]  ARF_OutDSel;
  logic [2:0]  ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic        IR_LH;
  logic        IR_Write;
  logic        Mem_WR;
  logic        Mem_CS;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic        MuxCSel;
  logic        Halted;
  logic        Illegal;
  logic [15:0] InstrCount;

  modport master (
    input  IROut, FlagsOut,
    output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
           ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
           ALU_FunSel, ALU_WF, IR_LH, IR_Write, Mem_WR, Mem_CS,
           MuxASel, MuxBSel, MuxCSel, Halted, Illegal, InstrCount
  );

  modport slave (
    output IROut, FlagsOut,
    input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
           ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
           ALU_FunSel, ALU_WF, IR_LH, IR_Write, Mem_WR, Mem_CS,
           MuxASel, MuxBSel, MuxCSel, Halted, Illegal, InstrCount
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute controller: INIT, two byte fetches, one
// execute cycle, and a HALT state left only through Reset.
module control_sequencer #(
  parameter logic [2:0] FS_DEC    = 3'b000,
  parameter logic [2:0] FS_INC    = 3'b001,
  parameter logic [2:0] FS_LOAD   = 3'b010,
  parameter logic [2:0] FS_CLEAR  = 3'b011,
  parameter logic [4:0] ALU_ADD   = 5'b10100,
  parameter logic [4:0] ALU_PASSA = 5'b10000
) (
  input  logic                 Clock,
  input  logic                 Reset,
  control_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_INIT, S_FETCH_L, S_FETCH_H, S_EXEC, S_HALT
  } state_t;

  state_t      r_state;
  logic        r_illegal;
  logic [15:0] r_count;

  logic [5:0]  w_op;
  logic [1:0]  w_rd, w_rs1, w_rs2;
  logic        w_legal;

  assign w_op    = bus.IROut[15:10];
  assign w_rd    = bus.IROut[9:8];
  assign w_rs1   = bus.IROut[7:6];
  assign w_rs2   = bus.IROut[5:4];
  assign w_legal = (w_op <= 6'h06) || (w_op == 6'h3F);

  // Register index i clears bit (3-i): R1 is bit 3 down to R4 at bit 0.
  function automatic logic [3:0] reg_sel(input logic [1:0] idx);
    return ~(4'b1000 >> idx);
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= S_INIT;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      case (r_state)
        S_INIT:    r_state <= S_FETCH_L;
        S_FETCH_L: r_state <= S_FETCH_H;
        S_FETCH_H: r_state <= S_EXEC;
        S_EXEC: begin
          r_count <= r_count + 16'd1;
          if (!w_legal) r_illegal <= 1'b1;
          r_state <= (w_op == 6'h3F) ? S_HALT : S_FETCH_L;
        end
        S_HALT:    r_state <= S_HALT;
        default:   r_state <= S_INIT;
      endcase
    end
  end

  always_comb begin
    bus.RF_OutASel  = '0;
    bus.RF_OutBSel  = '0;
    bus.RF_FunSel   = '0;
    bus.RF_RegSel   = '1;
    bus.RF_ScrSel   = '1;
    bus.ARF_OutCSel = '0;
    bus.ARF_OutDSel = '0;
    bus.ARF_FunSel  = '0;
    bus.ARF_RegSel  = '1;
    bus.ALU_FunSel  = '0;
    bus.ALU_WF      = 1'b0;
    bus.IR_LH       = 1'b0;
    bus.IR_Write    = 1'b0;
    bus.Mem_WR      = 1'b0;
    bus.Mem_CS      = 1'b1;
    bus.MuxASel     = '0;
    bus.MuxBSel     = '0;
    bus.MuxCSel     = 1'b0;
    // Reset overrides the decoded word so a mid-instruction reset is inert.
    if (!Reset) begin
      case (r_state)
        S_INIT: begin
          bus.ARF_FunSel = FS_CLEAR;
          bus.ARF_RegSel = 3'b000;
          bus.RF_FunSel  = FS_CLEAR;
          bus.RF_RegSel  = 4'b0000;
          bus.RF_ScrSel  = 4'b0000;
        end
        S_FETCH_L, S_FETCH_H: begin
          bus.ARF_OutDSel = 2'b00;
          bus.Mem_CS      = 1'b0;
          bus.IR_Write    = 1'b1;
          bus.IR_LH       = (r_state == S_FETCH_H);
          bus.ARF_RegSel  = 3'b011;
          bus.ARF_FunSel  = FS_INC;
        end
        S_EXEC: begin
          case (w_op)
            6'h00: begin
              bus.MuxBSel    = 2'b11;
              bus.ARF_FunSel = FS_LOAD;
              bus.ARF_RegSel = 3'b011;
            end
            6'h01: begin
              bus.MuxASel   = 2'b11;
              bus.RF_FunSel = FS_LOAD;
              bus.RF_RegSel = reg_sel(w_rd);
            end
            6'h02: begin
              bus.RF_OutASel = {1'b0, w_rs1};
              bus.RF_OutBSel = {1'b0, w_rs2};
              bus.ALU_FunSel = ALU_ADD;
              bus.ALU_WF     = 1'b1;
              bus.MuxASel    = 2'b00;
              bus.RF_FunSel  = FS_LOAD;
              bus.RF_RegSel  = reg_sel(w_rd);
            end
            6'h03: begin
              bus.ARF_OutDSel = 2'b10;
              bus.Mem_CS      = 1'b0;
              bus.MuxASel     = 2'b10;
              bus.RF_FunSel   = FS_LOAD;
              bus.RF_RegSel   = reg_sel(w_rd);
            end
            6'h04: begin
              bus.RF_OutASel  = {1'b0, w_rd};
              bus.ALU_FunSel  = ALU_PASSA;
              bus.MuxCSel     = 1'b0;
              bus.ARF_OutDSel = 2'b10;
              bus.Mem_CS      = 1'b0;
              bus.Mem_WR      = 1'b1;
            end
            6'h05: begin
              if (!bus.FlagsOut[3]) begin
                bus.MuxBSel    = 2'b11;
                bus.ARF_FunSel = FS_LOAD;
                bus.ARF_RegSel = 3'b011;
              end
            end
            6'h06: begin
              bus.ARF_FunSel = FS_INC;
              bus.ARF_RegSel = 3'b110;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.Halted     = !Reset && (r_state == S_HALT);
  assign bus.Illegal    = !Reset && r_illegal;
  assign bus.InstrCount = Reset ? '0 : r_count;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller; drives every control input of the ALU-system datapath (RF, ARF, ALU, IR, memory, muxes A/B/C).
- Observes IROut and FlagsOut only.
- Fixed 3-cycle instruction timing; 1 initialisation cycle after reset; HALT state.

Parameters:
- FS_DEC, 3'b000, RF/ARF FunSel decrement
- FS_INC, 3'b001, RF/ARF FunSel increment
- FS_LOAD, 3'b010, RF/ARF FunSel load from I
- FS_CLEAR, 3'b011, RF/ARF FunSel clear
- ALU_ADD, 5'b10100, ALU_FunSel 16-bit A+B
- ALU_PASSA, 5'b10000, ALU_FunSel 16-bit pass A

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high
- IROut  in  16  instruction register contents
- FlagsOut  in  4  ALU flags {Z,C,N,O}; Z = bit 3
- RF_OutASel, RF_OutBSel  out  3 each  RF read selects
- RF_FunSel  out  3
- RF_RegSel  out  4  active-low, bit3=R1..bit0=R4
- RF_ScrSel  out  4  active-low
- ARF_OutCSel, ARF_OutDSel  out  2 each  00=PC, 01=SP, 10=AR
- ARF_FunSel  out  3
- ARF_RegSel  out  3  active-low {PC,SP,AR}
- ALU_FunSel  out  5
- ALU_WF  out  1  flag write enable
- IR_LH  out  1  0=load low byte, 1=high
- IR_Write  out  1
- Mem_WR  out  1  1=write
- Mem_CS  out  1  active-low
- MuxASel, MuxBSel  out  2 each  00=ALUOut, 01=OutC, 10=MemOut, 11=IR[7:0]
- MuxCSel  out  1
- Halted  out  1  high in HALT
- Illegal  out  1  sticky, set on undefined opcode
- InstrCount  out  16  retired-instruction counter

Behaviour:
- Idle control word (default, all states unless overridden): RegSel/ScrSel/ARF_RegSel all ones; IR_Write=0; ALU_WF=0; Mem_CS=1; Mem_WR=0; all selects 0.
- Outputs are combinational from state and IROut; state, Illegal and InstrCount are registered.
- Reset (any state, mid-instruction included) -> INIT next cycle. While Reset=1: idle word, Halted=0, Illegal=0, InstrCount=0.
- INIT (1 cycle):
  - ARF_FunSel=FS_CLEAR, ARF_RegSel=3'b000 (PC,SP,AR cleared).
  - RF_FunSel=FS_CLEAR, RF_RegSel=4'b0000, RF_ScrSel=4'b0000.
  - -> FETCH_L.
- FETCH_L: ARF_OutDSel=00; Mem_CS=0; Mem_WR=0; IR_Write=1; IR_LH=0; ARF_RegSel=3'b011; ARF_FunSel=FS_INC -> FETCH_H.
- FETCH_H: same as FETCH_L but IR_LH=1 -> EXEC.
- Memory read is asynchronous: MemOut is valid in the cycle its Address is driven.
- EXEC: decode IROut[15:10]. Rd=IR[9:8], Rs1=IR[7:6], Rs2=IR[5:4]; register index i maps to RF_OutxSel={1'b0,i} and RF_RegSel with bit (3-i) cleared.
  - 0x00 BRA: MuxBSel=11, ARF_FunSel=FS_LOAD, ARF_RegSel=3'b011.
  - 0x01 LDI: MuxASel=11, RF_FunSel=FS_LOAD, RegSel(Rd).
  - 0x02 ADD: OutASel=Rs1, OutBSel=Rs2, ALU_FunSel=ALU_ADD, ALU_WF=1, MuxASel=00, RF_FunSel=FS_LOAD, RegSel(Rd).
  - 0x03 LD: ARF_OutDSel=10, Mem_CS=0, MuxASel=10, RF_FunSel=FS_LOAD, RegSel(Rd). Byte is zero-extended.
  - 0x04 ST: OutASel=Rd, ALU_FunSel=ALU_PASSA, ALU_WF=0, MuxCSel=0, ARF_OutDSel=10, Mem_CS=0, Mem_WR=1.
  - 0x05 BNE: if FlagsOut[3]==0, drive the BRA word; else idle word.
  - 0x06 INCAR: ARF_FunSel=FS_INC, ARF_RegSel=3'b110.
  - 0x3F HLT: idle word -> HALT.
  - Any other opcode: idle word, Illegal<=1.
- EXEC always increments InstrCount; the counter wraps 0xFFFF->0x0000.
- EXEC -> FETCH_L, except HLT -> HALT.
- HALT: idle word, Halted=1; leaves HALT only on Reset.
- Illegal clears only on Reset.
- PC increments twice per fetch; a branch target in EXEC overrides the PC, and the next fetch uses the target.

Test Plan:
- Reset held 3 cycles, then released -> one INIT cycle with ARF_RegSel=000 and RF_RegSel=0000, then FETCH_L with Mem_CS=0, IR_Write=1, IR_LH=0; InstrCount=0.
- Reset asserted during FETCH_H -> next cycle idle word; INIT on the first cycle after release; Illegal and InstrCount cleared.
- IROut=0x0512 in EXEC (LDI R1,0x12) -> MuxASel=11, RF_FunSel=010, RF_RegSel=1011; InstrCount increments by 1; next state FETCH_L.
- IROut=0x0890 (ADD R0=R2+R1) -> RF_OutASel=010, RF_OutBSel=001, ALU_FunSel=10100, ALU_WF=1, RF_RegSel=0111.
- BNE (IROut=0x1440) exercised twice:
  - FlagsOut=4'b1000 -> idle word, PC not loaded.
  - FlagsOut=4'b0000 -> MuxBSel=11, ARF_RegSel=011, ARF_FunSel=010.
- IROut=0x2000 (undefined opcode) -> Illegal=1, returns to FETCH_L. Then IROut=0xFC00 (HLT) -> Halted=1 held 10 cycles with the idle word; Reset clears Halted and Illegal.
